// File: rtl/boton_pkg.sv
// Shared types and default timing for the button press classifier.
// Defaults assume the 10 MHz lab clock (100 ns period).
package boton_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } boton_state_e;

    localparam int unsigned CLK_HZ                = 10_000_000;
    // 0.5 s hold for a long press, 0.2 s auto-repeat period.
    localparam int unsigned LONG_CYCLES_DEFAULT   = 5_000_000;
    localparam int unsigned REPEAT_CYCLES_DEFAULT = 2_000_000;
    localparam int unsigned CNT_W_DEFAULT         = 8;

endpackage

// File: rtl/hold_counter.sv
// Clear/enable counter that saturates at MAX and flags the terminal value MAX-1.
module hold_counter #(
    parameter int unsigned MAX = 8,
    localparam int unsigned W  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] MaxVal = W'(MAX);
    localparam logic [W-1:0] TcVal  = W'(MAX - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TcVal);

endmodule

// File: rtl/button_press_classifier.sv
// Turns a debounced button level into short/long/auto-repeat pulses plus a short-press count.
// Define BOTON_REPEAT_EN to enable auto-repeat pulses while a long press is held.
module button_press_classifier
    import boton_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boton_debounce_pi,
    output logic             press_corto_o,
    output logic             press_largo_o,
    output logic             repeat_o,
    output logic [CNT_W-1:0] contador_o,
    output logic [1:0]       estado_o
);

    boton_state_e     state_q, state_d;
    logic             corto_q, corto_d;
    logic             largo_q, largo_d;
    logic [CNT_W-1:0] contador_q, contador_d;

    logic hold_en, hold_clr, hold_tc;

    // Counter holds 0 in IDLE, so the first high sample lands it on 1.
    hold_counter #(
        .MAX (LONG_CYCLES)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (hold_clr),
        .en_i  (hold_en),
        .tc_o  (hold_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (boton_debounce_pi) state_d = PRESSED;
            end
            PRESSED: begin
                if (!boton_debounce_pi) state_d = IDLE;
                else if (hold_tc)       state_d = LONG_HELD;
            end
            LONG_HELD: begin
                if (!boton_debounce_pi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_en    = boton_debounce_pi &&
                     ((state_q == IDLE) || ((state_q == PRESSED) && !hold_tc));
        hold_clr   = !hold_en;
        corto_d    = (state_q == PRESSED) && !boton_debounce_pi;
        largo_d    = (state_q == PRESSED) && boton_debounce_pi && hold_tc;
        contador_d = contador_q + CNT_W'(corto_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corto_q    <= 1'b0;
            largo_q    <= 1'b0;
            contador_q <= '0;
        end else begin
            corto_q    <= corto_d;
            largo_q    <= largo_d;
            contador_q <= contador_d;
        end
    end

`ifdef BOTON_REPEAT_EN
    logic rep_en, rep_clr, rep_tc;
    logic repeat_q, repeat_d;

    hold_counter #(
        .MAX (REPEAT_CYCLES)
    ) u_rep_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (rep_clr),
        .en_i  (rep_en),
        .tc_o  (rep_tc)
    );

    // Terminal count fires the pulse and restarts the period from 0.
    always_comb begin
        rep_en   = (state_q == LONG_HELD) && boton_debounce_pi && !rep_tc;
        rep_clr  = !rep_en;
        repeat_d = (state_q == LONG_HELD) && boton_debounce_pi && rep_tc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

    assign press_corto_o = corto_q;
    assign press_largo_o = largo_q;
    assign contador_o    = contador_q;
    assign estado_o      = state_q;

endmodule
